// File: rtl/wb_burst_master_if.sv
// -----------------------------------------------------------------------------
// wb_burst_master_if
//   Wishbone classic bus bundle between one initiator and one target.
//   Signals keep their initiator-side names (_o driven by the master,
//   _i driven by the slave), so both ends read the same way.
//     wbm_cyc_o  cycle            wbm_stb_o  strobe
//     wbm_we_o   write enable     wbm_sel_o  byte selects (4)
//     wbm_adr_o  address (32)     wbm_dat_o  write data (32)
//     wbm_dat_i  read data (32)   wbm_ack_i  acknowledge
//   Modports: master (bus initiator), slave (bus target).
// -----------------------------------------------------------------------------
interface wb_burst_master_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_burst_master.sv
// -----------------------------------------------------------------------------
// wb_burst_master
//   Turns a command (start address, beat count, direction) plus a write data
//   stream into single-beat Wishbone classic cycles at incrementing addresses.
//   Every beat is a four-phase handshake: stb until ack, then stb low and wait
//   for the slave to drop ack before the next beat starts.
//
//   Ports
//     clk, rst_n           clock, asynchronous active-low reset
//     cmd_vld/cmd_rdy      command handshake; cmd_wr, cmd_addr, cmd_len
//     wr_dat/wr_vld/wr_rdy write data stream (one word per write beat)
//     rd_dat/rd_vld        read data, rd_vld pulses once per read beat
//     busy                 transfer in progress
//     done                 one-cycle pulse at the end of every command
//     err                  sticky watchdog abort flag
//     wbm                  Wishbone bus (master modport)
//
//   Optional feature: define WB_BURST_MASTER_TIMEOUT_EN to enable a watchdog
//   that aborts a beat stuck in REQ or RELEASE for TIMEOUT_CYCLES cycles.
//   Without it err is tied low and the block waits for ack indefinitely.
// -----------------------------------------------------------------------------
module wb_burst_master #(
  parameter int LEN_W          = 16,
  parameter int ADDR_INC       = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic             cmd_wr,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      wr_dat,
  input  logic             wr_vld,
  output logic             wr_rdy,
  output logic [31:0]      rd_dat,
  output logic             rd_vld,
  output logic             busy,
  output logic             done,
  output logic             err,
  wb_burst_master_if.master wbm
);

  typedef enum logic [1:0] {IDLE, FETCH, REQ, RELEASE} state_t;

  state_t           state_q;
  logic [31:0]      addr_q;
  logic [31:0]      addr_d;
  logic [LEN_W-1:0] left_q;
  logic             wr_q;
  logic             cyc_q, stb_q, we_q;
  logic [31:0]      dat_o_q;
  logic [31:0]      rd_dat_q;
  logic             rd_vld_q, done_q, busy_q, cmd_rdy_q, wr_rdy_q;

  // Address wraps naturally modulo 2^32.
  assign addr_d = addr_q + 32'(ADDR_INC);

`ifdef WB_BURST_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             err_q;
  logic             tmo_hit;
  logic             stalled;

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  // A beat is stalled when the state it is in has not seen its exit event.
  assign stalled = ((state_q == REQ) && !wbm.wbm_ack_i) ||
                   ((state_q == RELEASE) && wbm.wbm_ack_i);
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      left_q    <= '0;
      wr_q      <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      dat_o_q   <= '0;
      rd_dat_q  <= '0;
      rd_vld_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      cmd_rdy_q <= 1'b0;
      wr_rdy_q  <= 1'b0;
`ifdef WB_BURST_MASTER_TIMEOUT_EN
      tmo_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; the pulse
      // defaults below are overridden by later assignments in the same block.
      rd_vld_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef WB_BURST_MASTER_TIMEOUT_EN
      tmo_q    <= tmo_q + 1'b1;
`endif
      unique case (state_q)
        IDLE: begin
          cmd_rdy_q <= 1'b1;
          if (cmd_vld && cmd_rdy_q) begin
`ifdef WB_BURST_MASTER_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            if (cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q    <= cmd_addr;
              left_q    <= cmd_len;
              wr_q      <= cmd_wr;
              busy_q    <= 1'b1;
              cmd_rdy_q <= 1'b0;
              if (cmd_wr) begin
                wr_rdy_q <= 1'b1;
                state_q  <= FETCH;
              end else begin
                cyc_q   <= 1'b1;
                stb_q   <= 1'b1;
                we_q    <= 1'b0;
                state_q <= REQ;
`ifdef WB_BURST_MASTER_TIMEOUT_EN
                tmo_q   <= '0;
`endif
              end
            end
          end
        end

        FETCH: begin
          if (wr_vld) begin
            dat_o_q  <= wr_dat;
            wr_rdy_q <= 1'b0;
            cyc_q    <= 1'b1;
            stb_q    <= 1'b1;
            we_q     <= 1'b1;
            state_q  <= REQ;
`ifdef WB_BURST_MASTER_TIMEOUT_EN
            tmo_q    <= '0;
`endif
          end
        end

        REQ: begin
          // An ack already high on entry (stale) is taken as this beat's ack.
          if (wbm.wbm_ack_i) begin
            stb_q <= 1'b0;
            if (!wr_q) begin
              rd_dat_q <= wbm.wbm_dat_i;
              rd_vld_q <= 1'b1;
            end
            state_q <= RELEASE;
`ifdef WB_BURST_MASTER_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
        end

        RELEASE: begin
          if (!wbm.wbm_ack_i) begin
            addr_q <= addr_d;
            left_q <= left_q - LEN_W'(1);
            if (left_q == LEN_W'(1)) begin
              cyc_q     <= 1'b0;
              we_q      <= 1'b0;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              cmd_rdy_q <= 1'b1;
              state_q   <= IDLE;
            end else if (wr_q) begin
              // Bus is released while the next write word is fetched.
              cyc_q    <= 1'b0;
              we_q     <= 1'b0;
              wr_rdy_q <= 1'b1;
              state_q  <= FETCH;
            end else begin
              stb_q   <= 1'b1;
              state_q <= REQ;
`ifdef WB_BURST_MASTER_TIMEOUT_EN
              tmo_q   <= '0;
`endif
            end
          end
        end

        default: state_q <= IDLE;
      endcase

`ifdef WB_BURST_MASTER_TIMEOUT_EN
      // Watchdog abort overrides whatever the case statement scheduled.
      if (stalled && tmo_hit) begin
        cyc_q     <= 1'b0;
        stb_q     <= 1'b0;
        we_q      <= 1'b0;
        err_q     <= 1'b1;
        done_q    <= 1'b1;
        busy_q    <= 1'b0;
        cmd_rdy_q <= 1'b1;
        state_q   <= IDLE;
      end
`endif
    end
  end

  assign cmd_rdy       = cmd_rdy_q;
  assign wr_rdy        = wr_rdy_q;
  assign rd_dat        = rd_dat_q;
  assign rd_vld        = rd_vld_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = stb_q;
  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_sel_o = {4{cyc_q}};
  assign wbm.wbm_adr_o = addr_q;
  assign wbm.wbm_dat_o = dat_o_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// -----------------------------------------------------------------------------
// tb_wb_burst_master
//   Randomized scoreboard bench for wb_burst_master. Stimulus tasks push the
//   expected bus beats, read data and completions into queues; a monitor
//   pops and compares whenever the DUT starts a beat, pulses rd_vld or done.
//   A small Wishbone slave model answers with random ack delay / hold time
//   and returns data derived from the address.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_burst_master;
  localparam int LEN_W    = 16;
  localparam int ADDR_INC = 1;
  localparam int TMO      = 16;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_vld, cmd_rdy, cmd_wr;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [31:0]      wr_dat;
  logic             wr_vld, wr_rdy;
  logic [31:0]      rd_dat;
  logic             rd_vld, busy, done, err;

  wb_burst_master_if bus();

  wb_burst_master #(.LEN_W(LEN_W), .ADDR_INC(ADDR_INC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_dat(wr_dat), .wr_vld(wr_vld), .wr_rdy(wr_rdy),
    .rd_dat(rd_dat), .rd_vld(rd_vld),
    .busy(busy), .done(done), .err(err),
    .wbm(bus.master)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  beat_t       exp_beats[$];
  logic [31:0] exp_rd[$];
  logic        exp_done[$];
  logic [31:0] wdata[$];

  // Slave controls
  logic never_ack = 1'b0;
  int   hold_fix  = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_f(input logic [31:0] a);
    return a - 32'h60;
  endfunction

  // Wishbone slave model: ack after 0..2 cycles, hold ack 0..3 cycles after
  // stb drops (or hold_fix cycles when set).
  initial begin : slave
    int dly, hold;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = '0;
    dly = 0;
    hold = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        bus.wbm_ack_i = 1'b0;
        dly = $urandom_range(0, 2);
      end else if (!bus.wbm_ack_i) begin
        if (bus.wbm_stb_o && !never_ack) begin
          if (dly == 0) begin
            bus.wbm_ack_i = 1'b1;
            bus.wbm_dat_i = rd_f(bus.wbm_adr_o);
            hold = (hold_fix >= 0) ? hold_fix : $urandom_range(0, 3);
            dly  = $urandom_range(0, 2);
          end else begin
            dly--;
          end
        end
      end else if (!bus.wbm_stb_o) begin
        if (hold == 0) bus.wbm_ack_i = 1'b0;
        else hold--;
      end
    end
  end

  // Monitor / scoreboard
  initial begin : monitor
    logic  prev_stb, prev_ack;
    beat_t b;
    prev_stb = 1'b0;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      check("sel_vs_cyc", 32'(bus.wbm_sel_o), 32'({4{bus.wbm_cyc_o}}));
      if (!busy) check("cyc_when_idle", 32'(bus.wbm_cyc_o), 32'd0);
      if (bus.wbm_stb_o && !prev_stb) begin
        if (exp_beats.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          b = exp_beats.pop_front();
          check("beat_adr", bus.wbm_adr_o, b.adr);
          check("beat_we", 32'(bus.wbm_we_o), 32'(b.we));
          check("beat_cyc", 32'(bus.wbm_cyc_o), 32'd1);
          check("ack_low_before_stb", 32'(prev_ack), 32'd0);
          if (b.we) check("beat_dat", bus.wbm_dat_o, b.dat);
        end
      end
      if (rd_vld) begin
        if (exp_rd.size() == 0) check("unexpected_rd_vld", 32'd1, 32'd0);
        else check("rd_dat", rd_dat, exp_rd.pop_front());
      end
      if (done) begin
        if (exp_done.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else check("done_err", 32'(err), 32'(exp_done.pop_front()));
      end
      prev_stb = bus.wbm_stb_o;
      prev_ack = bus.wbm_ack_i;
    end
  end

  // Command handshake; returns at the negedge just after the accept edge.
  task automatic issue(input logic wr, input logic [31:0] addr, input int len);
    int t = 0;
    while (!cmd_rdy && t < 500) begin @(negedge clk); t++; end
    check("cmd_rdy_wait", 32'(t < 500), 32'd1);
    cmd_vld  = 1'b1;
    cmd_wr   = wr;
    cmd_addr = addr;
    cmd_len  = LEN_W'(len);
    @(negedge clk);
    cmd_vld  = 1'b0;
  endtask

  task automatic stream_wr(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      wr_dat = wdata[i];
      wr_vld = 1'b1;
      while (!wr_rdy && t < 500) begin @(negedge clk); t++; end
      if (t >= 500) begin
        check("wr_rdy_wait", 32'd0, 32'd1);
        wr_vld = 1'b0;
        return;
      end
      @(negedge clk);
      wr_vld = 1'b0;
    end
  endtask

  // Reference model: beat i of a burst is at addr + i*ADDR_INC (mod 2^32).
  task automatic do_cmd(input logic wr, input logic [31:0] addr, input int len);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.adr = addr + 32'(i) * 32'(ADDR_INC);
      b.we  = wr;
      b.dat = wr ? wdata[i] : 32'd0;
      exp_beats.push_back(b);
      if (!wr) exp_rd.push_back(rd_f(b.adr));
    end
    exp_done.push_back(1'b0);
    issue(wr, addr, len);
    if (wr) stream_wr(len);
  endtask

  task automatic wait_done();
    int t = 0;
    while ((busy || exp_done.size() != 0) && t < 2000) begin @(negedge clk); t++; end
    check("wait_done", 32'(t < 2000), 32'd1);
    @(negedge clk);
    check("cyc_after_done", 32'(bus.wbm_cyc_o), 32'd0);
  endtask

  initial begin : global_guard
    #3_000_000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  initial begin : stim
    int t;
    rst_n    = 1'b0;
    cmd_vld  = 1'b0;
    cmd_wr   = 1'b0;
    cmd_addr = '0;
    cmd_len  = '0;
    wr_dat   = '0;
    wr_vld   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_busy_done_err", 32'({busy, done, err, rd_vld, wr_rdy}), 32'd0);
    check("rst_bus_ctl", 32'({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}), 32'd0);
    check("rst_adr", bus.wbm_adr_o, 32'd0);
    check("rst_dat", bus.wbm_dat_o | rd_dat, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_cmd_rdy", 32'(cmd_rdy), 32'd1);

    // Read burst at 0x100, data 0xA0..0xA2
    do_cmd(1'b0, 32'h100, 3);
    wait_done();

    // Write burst crossing the 32-bit address wrap
    wdata = '{32'h11, 32'h22};
    do_cmd(1'b1, 32'hFFFF_FFFF, 2);
    wait_done();

    // Slave holds ack 5 cycles after stb drops
    hold_fix = 5;
    do_cmd(1'b0, 32'h200, 3);
    wait_done();
    hold_fix = -1;

    // Zero-length command: done next cycle, no bus activity
    do_cmd(1'b0, 32'h500, 0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    wait_done();

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    // Slave never acks: watchdog aborts after TMO cycles in REQ
    begin
      beat_t b;
      int cnt = 0;
      never_ack = 1'b1;
      b.adr = 32'h300; b.we = 1'b0; b.dat = 32'd0;
      exp_beats.push_back(b);
      exp_done.push_back(1'b1);
      issue(1'b0, 32'h300, 3);
      t = 0;
      while (!bus.wbm_stb_o && t < 100) begin @(negedge clk); t++; end
      while (bus.wbm_stb_o && cnt < 200) begin @(negedge clk); cnt++; end
      check("timeout_stb_cycles", 32'(cnt), 32'(TMO));
      wait_done();
      check("timeout_err_sticky", 32'(err), 32'd1);
      never_ack = 1'b0;
      do_cmd(1'b0, 32'h400, 1);
      check("err_cleared", 32'(err), 32'd0);
      wait_done();
    end
`endif

    // Reset in the middle of a write beat
    begin
      beat_t b;
      b.adr = 32'h700; b.we = 1'b1; b.dat = 32'hCAFE_0001;
      exp_beats.push_back(b);
      issue(1'b1, 32'h700, 3);
      wr_dat = 32'hCAFE_0001;
      wr_vld = 1'b1;
      t = 0;
      while (!bus.wbm_stb_o && t < 100) begin @(negedge clk); t++; end
      check("rst_test_stb_seen", 32'(bus.wbm_stb_o), 32'd1);
      wr_vld = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_cyc_stb_busy", 32'({bus.wbm_cyc_o, bus.wbm_stb_o, busy}), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      wdata = '{32'h5151_0000, 32'h5151_0001};
      do_cmd(1'b1, 32'h800, 2);
      wait_done();
    end

    // Randomized commands
    for (int n = 0; n < 24; n++) begin
      logic        wr;
      logic [31:0] addr;
      int          len;
      wr   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      len  = $urandom_range(0, 4);
      wdata.delete();
      for (int i = 0; i < len; i++) wdata.push_back($urandom);
      do_cmd(wr, addr, len);
      wait_done();
    end

    repeat (4) @(negedge clk);
    check("beats_left", 32'(exp_beats.size()), 32'd0);
    check("rd_left", 32'(exp_rd.size()), 32'd0);
    check("done_left", 32'(exp_done.size()), 32'd0);
    check("final_err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
